// File: rtl/mem_axi_lite_master_pkg.sv
// Shared types and constants for the MEM-stage AXI4-Lite master:
// FSM state encoding, AXI response codes and the fixed protection attribute.
package mem_axi_lite_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access for every transfer.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/mem_axi_lite_master.sv
// MEM-stage load/store unit: turns one core request into one AXI4-Lite
// transaction and holds the pipeline until the response has been taken.
module mem_axi_lite_master
    import mem_axi_lite_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,

    output logic                      mem_read_write,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rdata_valid,
    output logic                      resp_err,

    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_n;
    logic                    aw_done, aw_done_n;
    logic                    w_done, w_done_n;
    logic [DATA_WIDTH-1:0]   rdata_n;
    logic                    rdata_valid_n;
    logic                    resp_err_n;
    logic                    awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;

    logic aw_fire, w_fire;

    assign aw_fire = m_awvalid && m_awready;
    assign w_fire  = m_wvalid && m_wready;

    // Address/data come straight from the request latches, so they cannot move under VALID.
    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;
    assign m_awprot = AXI_PROT_DEFAULT;
    assign m_arprot = AXI_PROT_DEFAULT;

    // Stall request to the hazard unit; released in DONE so the pipeline steps exactly once.
    always_comb begin
        mem_read_write = 1'b0;
        unique case (state)
            IDLE:                                  mem_read_write = req_valid;
            WR_REQ, WR_RESP, RD_REQ, RD_RESP:      mem_read_write = 1'b1;
            default:                               mem_read_write = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            resp_err    <= 1'b0;
            m_awvalid   <= 1'b0;
            m_wvalid    <= 1'b0;
            m_bready    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_rready    <= 1'b0;
        end else begin
            state       <= state_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            wstrb_q     <= wstrb_n;
            aw_done     <= aw_done_n;
            w_done      <= w_done_n;
            rdata       <= rdata_n;
            rdata_valid <= rdata_valid_n;
            resp_err    <= resp_err_n;
            m_awvalid   <= awvalid_n;
            m_wvalid    <= wvalid_n;
            m_bready    <= bready_n;
            m_arvalid   <= arvalid_n;
            m_rready    <= rready_n;
        end
    end

    // Next state plus next values of every registered output; VALIDs only ever fall on their own handshake.
    always_comb begin
        state_n       = state;
        addr_n        = addr_q;
        wdata_n       = wdata_q;
        wstrb_n       = wstrb_q;
        aw_done_n     = aw_done;
        w_done_n      = w_done;
        rdata_n       = rdata;
        rdata_valid_n = 1'b0;
        resp_err_n    = 1'b0;
        awvalid_n     = m_awvalid;
        wvalid_n      = m_wvalid;
        bready_n      = m_bready;
        arvalid_n     = m_arvalid;
        rready_n      = m_rready;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_n    = req_addr;
                    wdata_n   = req_wdata;
                    wstrb_n   = req_wstrb;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    if (req_write) begin
                        state_n   = WR_REQ;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_REQ;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (aw_fire) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (w_fire) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if (aw_done_n && w_done_n) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    bready_n   = 1'b0;
                    resp_err_n = resp_is_err(m_bresp);
                    state_n    = DONE;
                end
            end
            RD_REQ: begin
                if (m_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_rvalid) begin
                    rready_n      = 1'b0;
                    rdata_n       = m_rdata;
                    rdata_valid_n = 1'b1;
                    resp_err_n    = resp_is_err(m_rresp);
                    state_n       = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
